// File: rtl/hilo_div_sequencer_if.sv
// hilo_div_sequencer_if: bundles the control-unit request, the divider
// result/flag inputs, and the HI/LO, status and start outputs of the
// HI/LO sequencer.
//
// Handshake: op_valid/op/wdata form a single-cycle request. The sequencer
// samples the request only while its FSM is idle. The request is accepted
// on the rising edge in which op_valid is high, op is non-zero and the
// FSM is idle. No ready signal is returned; control must hold off while
// busy is high, because a request made while busy is dropped. Every
// accepted request produces exactly one registered done pulse.
//
// The master modport belongs to the control/divider side. The slave
// modport belongs to the sequencer.
interface hilo_div_sequencer_if;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] div_high;
    logic [31:0] div_low;
    logic        div_div0;
    logic        div_start;
    logic        busy;
    logic        done;
    logic        div0_exc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_dbg;

    modport master (
        output op_valid, op, wdata, div_high, div_low, div_div0,
        input  div_start, busy, done, div0_exc, hi, lo, state_dbg
    );

    modport slave (
        input  op_valid, op, wdata, div_high, div_low, div_div0,
        output div_start, busy, done, div0_exc, hi, lo, state_dbg
    );
endinterface

// File: rtl/hilo_div_sequencer.sv
// hilo_div_sequencer: owns the MIPS HI/LO registers.
//
// The block sequences a DIV through the fixed-latency iterative divider:
//   - it traps divide-by-zero,
//   - it pulses div_start,
//   - it counts DIV_LATENCY cycles,
//   - it captures remainder/quotient into HI/LO on a single edge.
// It also performs MTHI/MTLO writes. Every output is driven by a register,
// so there is no combinational path from an input to an output.
//
// Optional build macro: DIV0_STICKY_EN
//   - Defined: div0_exc stays high after a divide-by-zero until the next
//     accepted op, or until reset.
//   - Undefined: div0_exc is a one-cycle pulse that coincides with done.
//
// DIV_LATENCY must be within 2..63, and 2**CNT_W must exceed DIV_LATENCY.
module hilo_div_sequencer #(
    parameter int DIV_LATENCY = 34,
    parameter int CNT_W       = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    hilo_div_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div0_q, div0_d;
    logic [31:0]       hi_q, lo_q;
    logic              hi_wr, lo_wr, cap_wr;
    logic              accept;

    // A request only counts when the FSM is idle. In WAIT and CAPTURE the
    // request is dropped, not queued.
    assign accept = (state_q == S_IDLE) && bus.op_valid && (bus.op != OP_NONE);

    // State, counter and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    // Next-state logic, next values of the registered outputs, and the
    // HI/LO write enables.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        hi_wr   = 1'b0;
        lo_wr   = 1'b0;
        cap_wr  = 1'b0;
`ifdef DIV0_STICKY_EN
        // Hold the flag until some op is accepted. If that op is itself a
        // divide-by-zero, the IDLE branch below sets the flag again.
        div0_d  = accept ? 1'b0 : div0_q;
`else
        div0_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_DIV: begin
                            if (bus.div_div0) begin
                                // Trap now. The divider is never started,
                                // so HI/LO keep their old values.
                                done_d = 1'b1;
                                div0_d = 1'b1;
                            end else begin
                                start_d = 1'b1;
                                busy_d  = 1'b1;
                                cnt_d   = LAT_LOAD;
                                state_d = S_WAIT;
                            end
                        end
                        OP_MTHI: begin
                            hi_wr  = 1'b1;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_wr  = 1'b1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            S_WAIT: begin
                // The counter holds DIV_LATENCY during the div_start cycle.
                // When it reaches 1, the next cycle is the one in which the
                // divider outputs are final.
                busy_d = 1'b1;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                // HI and LO are written on this one edge. busy falls in the
                // same cycle that done rises.
                cap_wr  = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // HI/LO architectural registers. A divider capture writes both at once;
    // MTHI and MTLO each write one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (cap_wr) begin
            hi_q <= bus.div_high;
            lo_q <= bus.div_low;
        end else begin
            if (hi_wr) begin
                hi_q <= bus.wdata;
            end
            if (lo_wr) begin
                lo_q <= bus.wdata;
            end
        end
    end

    assign bus.div_start = start_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.div0_exc  = div0_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/hilo_div_sequencer.md
Name: hilo_div_sequencer

Overview:
- Sits directly downstream of the iterative divider in the multicycle MIPS datapath and owns the HI/LO architectural registers.
- On a DIV request from the control unit it:
  - checks for divide-by-zero,
  - pulses the divider's start input,
  - counts the divider's fixed latency,
  - captures the divider's high/low results into HI/LO.
- Also services MTHI/MTLO writes.
- Drives hi/lo to the MFHI/MFLO datapath mux.

Parameters:
- DIV_LATENCY, 34: cycles from the div_start cycle (exclusive) to the cycle in which div_high/div_low are final and captured. Legal range 2..63.
- CNT_W, 6: width of the latency down-counter. Must satisfy 2^CNT_W > DIV_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  request strobe from control, sampled only in IDLE.
- op  in  2  operation: 00 none, 01 DIV, 10 MTHI, 11 MTLO.
- wdata  in  32  rs value for MTHI/MTLO.
- div_high  in  32  divider remainder output.
- div_low  in  32  divider quotient output.
- div_div0  in  1  divider's combinational divisor==0 flag.
- div_start  out  1  start pulse to divider.
- busy  out  1  high while a DIV is in flight; control stalls on it.
- done  out  1  one-cycle completion pulse for any accepted op.
- div0_exc  out  1  divide-by-zero exception to control/EPC logic.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; hi=lo=0; div_start=busy=done=div0_exc=0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, WAIT, CAPTURE.
- IDLE:
  - op_valid=1, op=01, div_div0=1:
    - no start; hi/lo unchanged.
    - next cycle done=1 and div0_exc=1 for one cycle.
    - stay IDLE.
  - op_valid=1, op=01, div_div0=0:
    - next cycle div_start=1 for exactly one cycle, busy=1.
    - counter loaded with DIV_LATENCY; go WAIT.
  - op_valid=1, op=10: next edge hi<=wdata; next cycle done=1; stay IDLE.
  - op_valid=1, op=11: next edge lo<=wdata; next cycle done=1; stay IDLE.
  - op=00 or op_valid=0: no action.
- WAIT:
  - counter decrements each cycle; busy=1.
  - When counter reaches 1, go CAPTURE.
  - op_valid is ignored in WAIT and CAPTURE; no queueing, the request is dropped.
- CAPTURE:
  - hi<=div_high, lo<=div_low.
  - done=1 the following cycle; busy drops with done; return to IDLE.
- Total DIV latency: op_valid cycle to done cycle = DIV_LATENCY+2 cycles.
- HI/LO are never partially updated. A DIV writes both on the same edge.
- Operand sign handling belongs to the divider. This block captures div_high/div_low verbatim.
- Reset mid-DIV: all state clears immediately. A later div_start is only issued for a new request.
- Back-to-back: a new op is accepted in the same cycle done is high, since the FSM is already in IDLE.

Optional Feature:
- Macro DIV0_STICKY_EN.
- Defined: div0_exc is held high after a divide-by-zero until the next accepted op of any kind. It clears on the edge that accepts that op; reset also clears it.
- Undefined: div0_exc is a single-cycle pulse coincident with done.

Test Plan:
- Reset, then DIV with A=7, B=2 → div_start one cycle after request; done at request+36 with DIV_LATENCY=34; hi=1, lo=3; busy high for exactly 35 cycles.
- DIV with A=-7, B=2 → hi=32'hFFFFFFFF, lo=32'hFFFFFFFD; neither register changes before the CAPTURE edge.
- DIV with B=0 (hi=lo=5 preloaded via MTHI/MTLO) → no div_start; done and div0_exc next cycle; hi=lo=5. With DIV0_STICKY_EN, div0_exc stays high until a subsequent MTHI is accepted.
- MTHI 32'hDEADBEEF, then MTLO 32'h12345678 on consecutive cycles → two done pulses; hi=32'hDEADBEEF, lo=32'h12345678.
- MTLO issued 5 cycles into a DIV (A=100, B=7) → ignored; lo=14, hi=2 at done.
- rst asserted 10 cycles into a DIV → busy=0 and hi=lo=0 immediately; no done pulse; a fresh DIV 9/3 afterwards yields lo=3, hi=0.
